rw_issue_scheduler: RTL and testbench

- Per-bank request scheduler that owns slot allocation and issue ordering for the front-end global request array (separate read and write slot pools).
- Hands the mapper the index of a free slot per type, keeps age order per type, and chooses which stored request to issue next.
- Issue policy: reads have priority; writes drain when the write pool crosses a high watermark. Each choice goes to the array as (valid, index, type) under a valid/ready handshake with the command path.

---
 rtl/rw_issue_scheduler.sv | 139 +++++++++++++
 tb/tb_rw_issue_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rw_issue_scheduler.sv
// Per-bank read/write slot allocator and issue scheduler for the global request array.
// Separate read and write pools, age-ordered per type, read priority with write-drain hysteresis.
module rw_issue_scheduler #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned WR_HIGH_WM = 12,
  parameter int unsigned WR_LOW_WM  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic             push_type,
  output logic [IDX_W-1:0] rd_free_index,
  output logic             rd_free_valid,
  output logic [IDX_W-1:0] wr_free_index,
  output logic             wr_free_valid,
  output logic             sched_valid,
  output logic [IDX_W-1:0] sched_index,
  output logic             sched_type,
  input  logic             issue_ready,
  output logic [IDX_W:0]   rd_count,
  output logic [IDX_W:0]   wr_count,
  output logic             push_overflow
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_MODE   = 2'd1,
    WRITE_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  logic [DEPTH-1:0] rd_occ_q, rd_occ_d, wr_occ_q, wr_occ_d;
  logic [IDX_W-1:0] rd_fifo_q [DEPTH];
  logic [IDX_W-1:0] wr_fifo_q [DEPTH];
  logic [IDX_W:0]   rd_wp_q, rd_rp_q, wr_wp_q, wr_rp_q;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             push_ovf_q;

  logic             rd_push, wr_push, rd_pop, wr_pop, handshake, wr_want;
  logic [IDX_W-1:0] rd_head, wr_head;

  // Lowest-numbered free slot; 0 when the pool is full (free_valid gates use).
  function automatic logic [IDX_W-1:0] lowest_free(input logic [DEPTH-1:0] occ);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!occ[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign rd_free_valid = ~&rd_occ_q;
  assign wr_free_valid = ~&wr_occ_q;
  assign rd_free_index = lowest_free(rd_occ_q);
  assign wr_free_index = lowest_free(wr_occ_q);

  assign rd_head = rd_fifo_q[rd_rp_q[IDX_W-1:0]];
  assign wr_head = wr_fifo_q[wr_rp_q[IDX_W-1:0]];

  assign sched_valid = ((state_q == READ_MODE)   && (rd_cnt_q != '0)) ||
                       ((state_q == WRITE_DRAIN) && (wr_cnt_q != '0));
  assign sched_type  = sched_valid && (state_q == WRITE_DRAIN);
  assign sched_index = !sched_valid ? '0 : ((state_q == WRITE_DRAIN) ? wr_head : rd_head);

  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;
  assign push_overflow = push_ovf_q;

  // Accepted push/pop events and post-update occupancy for this edge.
  always_comb begin
    handshake = sched_valid && issue_ready;
    rd_push   = push_valid && !push_type && rd_free_valid;
    wr_push   = push_valid &&  push_type && wr_free_valid;
    rd_pop    = handshake && (state_q == READ_MODE);
    wr_pop    = handshake && (state_q == WRITE_DRAIN);

    rd_occ_d = rd_occ_q;
    wr_occ_d = wr_occ_q;
    if (rd_push) rd_occ_d[rd_free_index] = 1'b1;
    if (wr_push) wr_occ_d[wr_free_index] = 1'b1;
    if (rd_pop)  rd_occ_d[rd_head] = 1'b0;
    if (wr_pop)  wr_occ_d[wr_head] = 1'b0;

    rd_cnt_d = rd_cnt_q + CNT_W'(rd_push) - CNT_W'(rd_pop);
    wr_cnt_d = wr_cnt_q + CNT_W'(wr_push) - CNT_W'(wr_pop);
    wr_want  = (wr_cnt_d >= CNT_W'(WR_HIGH_WM)) || ((rd_cnt_d == '0) && (wr_cnt_d != '0));
  end

  // Slot contents carry no reset: validity is tracked by pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rd_push) rd_fifo_q[rd_wp_q[IDX_W-1:0]] <= rd_free_index;
    if (wr_push) wr_fifo_q[wr_wp_q[IDX_W-1:0]] <= wr_free_index;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_occ_q   <= '0;
      wr_occ_q   <= '0;
      rd_wp_q    <= '0;
      rd_rp_q    <= '0;
      wr_wp_q    <= '0;
      wr_rp_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      push_ovf_q <= 1'b0;
    end else begin
      rd_occ_q   <= rd_occ_d;
      wr_occ_q   <= wr_occ_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      push_ovf_q <= push_valid && (push_type ? !wr_free_valid : !rd_free_valid);
      if (rd_push) rd_wp_q <= rd_wp_q + 1'b1;
      if (wr_push) wr_wp_q <= wr_wp_q + 1'b1;
      if (rd_pop)  rd_rp_q <= rd_rp_q + 1'b1;
      if (wr_pop)  wr_rp_q <= wr_rp_q + 1'b1;

      // Mode only moves when no issue is stalled, so a presented issue stays put.
      if (!sched_valid || handshake) begin
        case (state_q)
          WRITE_DRAIN: begin
            if ((rd_cnt_d != '0) && (wr_cnt_d <= CNT_W'(WR_LOW_WM))) state_q <= READ_MODE;
            else if ((rd_cnt_d == '0) && (wr_cnt_d == '0))          state_q <= IDLE;
            else                                                     state_q <= WRITE_DRAIN;
          end
          default: begin
            if (wr_want)                state_q <= WRITE_DRAIN;
            else if (rd_cnt_d != '0)    state_q <= READ_MODE;
            else                        state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rw_issue_scheduler.sv
// Scoreboard bench for rw_issue_scheduler: queue-based reference model predicts every
// cycle's outputs and the ordered issue stream; a negedge monitor checks each handshake.
module tb_rw_issue_scheduler;

  localparam int IDX_W = 4;
  localparam int DEPTH = 16;
  localparam int HIGH  = 12;
  localparam int LOW   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push_valid = 1'b0;
  logic             push_type = 1'b0;
  logic             issue_ready = 1'b0;
  logic [IDX_W-1:0] rd_free_index, wr_free_index, sched_index;
  logic             rd_free_valid, wr_free_valid, sched_valid, sched_type, push_overflow;
  logic [IDX_W:0]   rd_count, wr_count;

  rw_issue_scheduler #(.IDX_W(IDX_W), .WR_HIGH_WM(HIGH), .WR_LOW_WM(LOW)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_type(push_type),
    .rd_free_index(rd_free_index), .rd_free_valid(rd_free_valid),
    .wr_free_index(wr_free_index), .wr_free_valid(wr_free_valid),
    .sched_valid(sched_valid), .sched_index(sched_index), .sched_type(sched_type),
    .issue_ready(issue_ready),
    .rd_count(rd_count), .wr_count(wr_count),
    .push_overflow(push_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-type age queues, slot-in-use tables, issue mode (0 idle, 1 read, 2 drain).
  int rdq[$];
  int wrq[$];
  bit rd_used[DEPTH];
  bit wr_used[DEPTH];
  int mode;
  bit ovf_m;
  int sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit used[DEPTH]);
    for (int i = 0; i < DEPTH; i++) if (!used[i]) return i;
    return -1;
  endfunction

  function automatic bit model_valid();
    return (mode == 1 && rdq.size() > 0) || (mode == 2 && wrq.size() > 0);
  endfunction

  task automatic model_reset();
    rdq.delete(); wrq.delete(); sb.delete();
    for (int i = 0; i < DEPTH; i++) begin rd_used[i] = 0; wr_used[i] = 0; end
    mode = 0; ovf_m = 0;
  endtask

  task automatic check_outputs();
    bit mv;
    mv = model_valid();
    chk("rd_free_valid", int'(rd_free_valid), int'(rdq.size() < DEPTH));
    chk("wr_free_valid", int'(wr_free_valid), int'(wrq.size() < DEPTH));
    if (rdq.size() < DEPTH) chk("rd_free_index", int'(rd_free_index), lowest(rd_used));
    if (wrq.size() < DEPTH) chk("wr_free_index", int'(wr_free_index), lowest(wr_used));
    chk("rd_count", int'(rd_count), rdq.size());
    chk("wr_count", int'(wr_count), wrq.size());
    chk("push_overflow", int'(push_overflow), int'(ovf_m));
    chk("sched_valid", int'(sched_valid), int'(mv));
    if (mv) begin
      chk("sched_type", int'(sched_type), (mode == 2) ? 1 : 0);
      chk("sched_index", int'(sched_index), (mode == 2) ? wrq[0] : rdq[0]);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the model through the edge.
  task automatic cycle(input bit pv, input bit pt, input bit ir);
    bit mv, hs;
    int fidx, popped, rc, wc;
    check_outputs();
    push_valid = pv; push_type = pt; issue_ready = ir;
    mv = model_valid();
    hs = mv && ir;
    fidx = -1;
    if (pv) fidx = pt ? lowest(wr_used) : lowest(rd_used);
    ovf_m = pv && (fidx < 0);
    if (hs) begin
      if (mode == 2) begin popped = wrq.pop_front(); wr_used[popped] = 0; sb.push_back(256 + popped); end
      else           begin popped = rdq.pop_front(); rd_used[popped] = 0; sb.push_back(popped); end
    end
    if (pv && fidx >= 0) begin
      if (pt) begin wr_used[fidx] = 1; wrq.push_back(fidx); end
      else    begin rd_used[fidx] = 1; rdq.push_back(fidx); end
    end
    if (!mv || hs) begin
      rc = rdq.size(); wc = wrq.size();
      if (mode == 2) begin
        if (rc > 0 && wc <= LOW)        mode = 1;
        else if (rc == 0 && wc == 0)    mode = 0;
      end else begin
        if (wc >= HIGH || (rc == 0 && wc > 0)) mode = 2;
        else if (rc > 0)                        mode = 1;
        else                                    mode = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    push_valid = 0; issue_ready = 0;
    rst = 1;
    #1;
    model_reset();
    check_outputs();
    chk("reset_sched_index", int'(sched_index), 0);
    chk("reset_sched_type", int'(sched_type), 0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Monitor: every completed handshake must match the oldest predicted issue; stalls must hold.
  bit       prev_stall = 0;
  int       prev_idx, prev_type;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", int'(sched_valid), 1);
          chk("stall_index", int'(sched_index), prev_idx);
          chk("stall_type", int'(sched_type), prev_type);
        end
        if (sched_valid && issue_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            chk("issue", int'(sched_type) * 256 + int'(sched_index), sb.pop_front());
          end
        end
        prev_stall = sched_valid && !issue_ready;
        prev_idx   = int'(sched_index);
        prev_type  = int'(sched_type);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    check_outputs();
    @(posedge clk); #1;
    rst = 0;

    // Three reads with ready held: slots 0,1,2 issued in order.
    repeat (3) cycle(1, 0, 1);
    repeat (3) cycle(0, 0, 1);
    chk("rd_drained", int'(rd_count), 0);

    // Fill the write pool with issue stalled, then overflow once.
    repeat (17) cycle(1, 1, 0);
    chk("wr_full_count", int'(wr_count), 16);
    chk("wr_full_free_valid", int'(wr_free_valid), 0);
    cycle(0, 0, 0);
    chk("overflow_cleared", int'(push_overflow), 0);
    repeat (17) cycle(0, 0, 1);

    // 12 writes + 2 reads, then drain to low watermark, reads, remaining writes.
    repeat (12) cycle(1, 1, 0);
    repeat (2)  cycle(1, 0, 0);
    repeat (16) cycle(0, 0, 1);
    chk("mix_drained", int'(rd_count) + int'(wr_count), 0);

    // Read stalled while writes cross the high watermark.
    cycle(1, 0, 0);
    repeat (13) cycle(1, 1, 0);
    repeat (16) cycle(0, 0, 1);

    // Same-cycle issue and push: freed slot 0 not reused until the next cycle.
    cycle(1, 0, 0);
    chk("reuse_first_slot", int'(sched_index), 0);
    cycle(1, 0, 1);
    chk("reuse_new_slot", int'(sched_index), 1);
    chk("reuse_free_slot0", int'(rd_free_index), 0);
    repeat (3) cycle(0, 0, 1);

    // Randomized phases with varying push rate, write mix and ready rate.
    for (int ph = 0; ph < 10; ph++) begin
      int p, r, w;
      p = $urandom_range(20, 95);
      r = $urandom_range(5, 90);
      w = $urandom_range(0, 100);
      repeat (300) cycle($urandom_range(0, 99) < p, $urandom_range(0, 99) < w,
                         $urandom_range(0, 99) < r);
    end
    repeat (40) cycle(0, 0, 1);

    // Mid-operation reset with pending reads and writes.
    repeat (5) cycle(1, 0, 0);
    repeat (5) cycle(1, 1, 0);
    do_reset();
    repeat (3) cycle(0, 0, 1);
    chk("post_reset_idle", int'(sched_valid), 0);
    repeat (4) cycle(1, $urandom_range(0, 1) == 1, 1);
    repeat (10) cycle(0, 0, 1);

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
